// File: rtl/keypad_controller.sv
// Synchronizes, debounces and arbitrates a 15-key pad into a held note index
// plus one-cycle mode/sound pulses for the synth core.
module keypad_controller #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic [14:0] keypad_i,
  output logic [3:0]  keycode,
  output logic        note_on,
  output logic        mode_key,
  output logic        sound_edge
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [14:0]      s1_q, s2_q, s_last_q, db_q, db_prev_q;
  logic [14:0]      db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [3:0]       owner_q, owner_d;
  logic [3:0]       keycode_q, keycode_d;
  logic             note_on_q, note_on_d;
  logic             mode_key_q, mode_key_d;
  logic             sound_edge_q, sound_edge_d;
  logic [12:0]      notes;

  function automatic logic [3:0] lowest(input logic [12:0] v);
    logic [3:0] idx;
    idx = 4'hF;
    for (int i = 12; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // One shared window: any change anywhere on the pad restarts it.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s2_q != s_last_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      db_d = s2_q;
    end
  end

  assign notes = db_q[12:0];

  // Hold-first arbitration; handover to the lowest remaining note is gapless.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|notes) begin
            state_d = HOLD;
            owner_d = lowest(notes);
          end
        end
        default: begin
          if (!notes[owner_q]) begin
            if (|notes) owner_d = lowest(notes);
            else        state_d = IDLE;
          end
        end
      endcase
    end
    keycode_d    = (state_d == HOLD) ? owner_d : 4'hF;
    note_on_d    = (state_d == HOLD);
    mode_key_d   = en & db_q[13] & ~db_prev_q[13];
    sound_edge_d = en & db_q[14] & ~db_prev_q[14];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s_last_q     <= '0;
      db_q         <= '0;
      db_prev_q    <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      owner_q      <= 4'hF;
      keycode_q    <= 4'hF;
      note_on_q    <= 1'b0;
      mode_key_q   <= 1'b0;
      sound_edge_q <= 1'b0;
    end else begin
      s1_q         <= keypad_i;
      s2_q         <= s1_q;
      s_last_q     <= s2_q;
      db_q         <= db_d;
      db_prev_q    <= db_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      owner_q      <= owner_d;
      keycode_q    <= keycode_d;
      note_on_q    <= note_on_d;
      mode_key_q   <= mode_key_d;
      sound_edge_q <= sound_edge_d;
    end
  end

  assign keycode    = keycode_q;
  assign note_on    = note_on_q;
  assign mode_key   = mode_key_q;
  assign sound_edge = sound_edge_q;

endmodule
